// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/LSU memory port arbiter: FSM states, port owners and the
// latched request record.
package mem_port_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_BE_W   = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RSP
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LSU
    } mem_owner_e;

    typedef struct packed {
        logic                  we;
        logic [MEM_BE_W-1:0]   be;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction at a
// time, with LSU priority bounded by a starvation counter that eventually forces IF through.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = MEM_ADDR_W,
    parameter int unsigned DATA_W     = MEM_DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_kill_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [DATA_W/8-1:0] lsu_be_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                instr_stall_o,
    output logic                data_stall_o
);

    localparam int unsigned      CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e       r_state;
    mem_owner_e       r_owner;
    logic [CNT_W-1:0] r_starve;
    logic             r_kill_pend;
    logic             r_mem_req;
    mem_req_t         r_req;

    logic     w_rsp;
    logic     w_arb_en;
    logic     w_if_part;
    logic     w_lsu_win;
    logic     w_if_win;
    logic     w_if_rvalid;
    logic     w_lsu_rvalid;
    mem_req_t w_if_attr;
    mem_req_t w_lsu_attr;

    // Arbitration happens when idle, or in the response cycle so the port can go back-to-back.
    assign w_rsp     = (r_state == ARB_RSP) && mem_rvalid_i;
    assign w_arb_en  = (r_state == ARB_IDLE) || w_rsp;
    assign w_if_part = if_req_i && !if_kill_i;
    assign w_lsu_win = w_arb_en && lsu_req_i && !(w_if_part && (r_starve == STARVE_LIM));
    assign w_if_win  = w_arb_en && w_if_part && !w_lsu_win;

    assign w_if_attr  = '{we: 1'b0, be: '1, addr: if_addr_i, wdata: '0};
    assign w_lsu_attr = '{we: lsu_we_i, be: lsu_be_i, addr: lsu_addr_i, wdata: lsu_wdata_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ARB_IDLE;
            r_owner     <= OWN_NONE;
            r_starve    <= '0;
            r_kill_pend <= 1'b0;
            r_mem_req   <= 1'b0;
            r_req       <= '0;
        end else begin
            if ((r_state == ARB_REQ) && mem_gnt_i) begin
                r_state   <= ARB_RSP;
                r_mem_req <= 1'b0;
            end
            if (w_arb_en) begin
                if (w_lsu_win) begin
                    r_state   <= ARB_REQ;
                    r_owner   <= OWN_LSU;
                    r_req     <= w_lsu_attr;
                    r_mem_req <= 1'b1;
                    if (!if_req_i) begin
                        r_starve <= '0;
                    end else if (r_starve != STARVE_LIM) begin
                        r_starve <= r_starve + CNT_W'(1);
                    end
                end else if (w_if_win) begin
                    r_state   <= ARB_REQ;
                    r_owner   <= OWN_IF;
                    r_req     <= w_if_attr;
                    r_mem_req <= 1'b1;
                    r_starve  <= '0;
                end else begin
                    r_state <= ARB_IDLE;
                    r_owner <= OWN_NONE;
                end
            end
            // A killed fetch cannot be withdrawn from memory; only its response is hidden.
            if (w_rsp) begin
                r_kill_pend <= 1'b0;
            end else if ((r_state != ARB_IDLE) && (r_owner == OWN_IF) && if_kill_i) begin
                r_kill_pend <= 1'b1;
            end
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_req.we;
    assign mem_be_o    = r_req.be;
    assign mem_addr_o  = r_req.addr;
    assign mem_wdata_o = r_req.wdata;

    assign if_gnt_o  = (r_state == ARB_REQ) && mem_gnt_i && (r_owner == OWN_IF);
    assign lsu_gnt_o = (r_state == ARB_REQ) && mem_gnt_i && (r_owner == OWN_LSU);

    assign w_if_rvalid  = w_rsp && (r_owner == OWN_IF) && !r_kill_pend && !if_kill_i;
    assign w_lsu_rvalid = w_rsp && (r_owner == OWN_LSU);

    assign if_rvalid_o  = w_if_rvalid;
    assign lsu_rvalid_o = w_lsu_rvalid;
    assign if_rdata_o   = w_if_rvalid ? mem_rdata_i : '0;
    assign lsu_rdata_o  = (w_lsu_rvalid && !r_req.we) ? mem_rdata_i : '0;

    assign instr_stall_o = if_req_i && !w_if_rvalid;
    assign data_stall_o  = lsu_req_i && !w_lsu_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle table, starvation and reset sequences, then
// randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned SMAX = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_i, if_kill_i, lsu_req_i, lsu_we_i;
    logic [31:0] if_addr_i, lsu_addr_i, lsu_wdata_i, mem_rdata_i;
    logic [3:0]  lsu_be_i;
    logic        mem_gnt_i, mem_rvalid_i;
    logic        if_gnt_o, if_rvalid_o, lsu_gnt_o, lsu_rvalid_o;
    logic [31:0] if_rdata_o, lsu_rdata_o, mem_addr_o, mem_wdata_o;
    logic        mem_req_o, mem_we_o, instr_stall_o, data_stall_o;
    logic [3:0]  mem_be_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(SMAX)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_kill_i    (if_kill_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .lsu_req_i    (lsu_req_i),
        .lsu_we_i     (lsu_we_i),
        .lsu_be_i     (lsu_be_i),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_gnt_o    (lsu_gnt_o),
        .lsu_rvalid_o (lsu_rvalid_o),
        .lsu_rdata_o  (lsu_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .instr_stall_o(instr_stall_o),
        .data_stall_o (data_stall_o)
    );

    always #5 clk_i = ~clk_i;

    // Directed cycle record: inputs {if_req, if_kill, lsu_req, lsu_we, gnt, rvalid},
    // outputs {mem_req, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid}, stalls {instr, data}.
    typedef struct {
        logic [5:0]  in;
        logic [31:0] rd;
        logic [4:0]  out;
        logic [31:0] ird;
        logic [31:0] lrd;
        logic [1:0]  st;
        logic [31:0] addr;
        logic        we;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic [5:0] in, input logic [31:0] rd, input logic [4:0] out,
                                input logic [31:0] ird, input logic [31:0] lrd,
                                input logic [1:0] st, input logic [31:0] addr, input logic we);
        vec_t v;
        v.in = in; v.rd = rd; v.out = out; v.ird = ird; v.lrd = lrd;
        v.st = st; v.addr = addr; v.we = we;
        return v;
    endfunction

    function automatic logic [159:0] bundle(input logic mreq, input logic ig, input logic lg,
                                            input logic irv, input logic lrv,
                                            input logic [31:0] ird, input logic [31:0] lrd,
                                            input logic ist, input logic dst,
                                            input logic [31:0] addr, input logic we,
                                            input logic [3:0] be, input logic [31:0] wdata);
        logic [68:0] attr;
        attr = mreq ? {addr, we, be, wdata} : 69'd0;
        return {20'd0, mreq, ig, lg, irv, lrv, ird, lrd, ist, dst, attr};
    endfunction

    function automatic logic [159:0] dut_bundle();
        return bundle(mem_req_o, if_gnt_o, lsu_gnt_o, if_rvalid_o, lsu_rvalid_o, if_rdata_o,
                      lsu_rdata_o, instr_stall_o, data_stall_o, mem_addr_o, mem_we_o,
                      mem_be_o, mem_wdata_o);
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic zero_inputs();
        if_req_i = 0; if_kill_i = 0; lsu_req_i = 0; lsu_we_i = 0;
        if_addr_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0; lsu_be_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    endtask

    task automatic do_reset(input bit chk);
        zero_inputs();
        rst_ni = 0;
        repeat (2) @(negedge clk_i);
        if (chk) check("reset state", dut_bundle(), 160'd0);
        rst_ni = 1;
    endtask

    // Reference model state: at most one transaction in flight.
    bit          m_busy, m_granted, m_killed, m_we;
    int          m_own, m_streak, m_out;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;

    initial begin
        logic [159:0] exp_b;
        logic [7:0]   exp_c, got_c;
        logic         e_mreq, e_ig, e_lg, e_resp, e_irv, e_lrv, ifp, free, s_ig, s_lg;
        logic [31:0]  e_ird, e_lrd;
        int           ngrant, cyc;

        tbl[0]  = mk(6'b001000, 32'h0,        5'b00000, 32'h0, 32'h0,        2'b01, 32'h0,   0);
        tbl[1]  = mk(6'b001010, 32'h0,        5'b10100, 32'h0, 32'h0,        2'b01, 32'h100, 0);
        tbl[2]  = mk(6'b000001, 32'hDEADBEEF, 5'b00001, 32'h0, 32'hDEADBEEF, 2'b00, 32'h0,   0);
        tbl[3]  = mk(6'b000000, 32'h0,        5'b00000, 32'h0, 32'h0,        2'b00, 32'h0,   0);
        tbl[4]  = mk(6'b101100, 32'h0,        5'b00000, 32'h0, 32'h0,        2'b11, 32'h0,   0);
        tbl[5]  = mk(6'b101110, 32'h0,        5'b10100, 32'h0, 32'h0,        2'b11, 32'h100, 1);
        tbl[6]  = mk(6'b100001, 32'hCAFEF00D, 5'b00001, 32'h0, 32'h0,        2'b10, 32'h0,   0);
        tbl[7]  = mk(6'b100010, 32'h0,        5'b11000, 32'h0, 32'h0,        2'b10, 32'h40,  0);
        tbl[8]  = mk(6'b000001, 32'h13,       5'b00010, 32'h13, 32'h0,       2'b00, 32'h0,   0);
        tbl[9]  = mk(6'b100000, 32'h0,        5'b00000, 32'h0, 32'h0,        2'b10, 32'h0,   0);
        tbl[10] = mk(6'b100010, 32'h0,        5'b11000, 32'h0, 32'h0,        2'b10, 32'h40,  0);
        tbl[11] = mk(6'b010000, 32'h0,        5'b00000, 32'h0, 32'h0,        2'b00, 32'h0,   0);
        tbl[12] = mk(6'b001001, 32'h11111111, 5'b00000, 32'h0, 32'h0,        2'b01, 32'h0,   0);
        tbl[13] = mk(6'b001010, 32'h0,        5'b10100, 32'h0, 32'h0,        2'b01, 32'h100, 0);
        tbl[14] = mk(6'b000001, 32'h22222222, 5'b00001, 32'h0, 32'h22222222, 2'b00, 32'h0,   0);
        tbl[15] = mk(6'b001100, 32'h0,        5'b00000, 32'h0, 32'h0,        2'b01, 32'h0,   0);
        for (int i = 16; i <= 20; i++)
            tbl[i] = mk(6'b001100, 32'h0,     5'b10000, 32'h0, 32'h0,        2'b01, 32'h100, 1);
        tbl[21] = mk(6'b001110, 32'h0,        5'b10100, 32'h0, 32'h0,        2'b01, 32'h100, 1);
        tbl[22] = mk(6'b000001, 32'h44444444, 5'b00001, 32'h0, 32'h0,        2'b00, 32'h0,   0);
        tbl[23] = mk(6'b000011, 32'h33333333, 5'b00000, 32'h0, 32'h0,        2'b00, 32'h0,   0);
        tbl[24] = mk(6'b000000, 32'h0,        5'b00000, 32'h0, 32'h0,        2'b00, 32'h0,   0);

        // Directed table.
        do_reset(1);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk_i); #1;
            {if_req_i, if_kill_i, lsu_req_i, lsu_we_i, mem_gnt_i, mem_rvalid_i} = tbl[i].in;
            mem_rdata_i = tbl[i].rd;
            if_addr_i = 32'h40; lsu_addr_i = 32'h100; lsu_be_i = 4'hF; lsu_wdata_i = 32'h12345678;
            @(negedge clk_i);
            exp_b = bundle(tbl[i].out[4], tbl[i].out[3], tbl[i].out[2], tbl[i].out[1],
                           tbl[i].out[0], tbl[i].ird, tbl[i].lrd, tbl[i].st[1], tbl[i].st[0],
                           tbl[i].addr, tbl[i].we, 4'hF,
                           (tbl[i].addr == 32'h40) ? 32'h0 : 32'h12345678);
            check($sformatf("table row %0d", i), dut_bundle(), exp_b);
        end

        // Starvation: LSU always requesting, IF held; every 5th slot goes to IF.
        do_reset(0);
        @(posedge clk_i); #1;
        if_req_i = 1; lsu_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
        if_addr_i = 32'h80; lsu_addr_i = 32'h200; lsu_be_i = 4'hF;
        ngrant = 0; cyc = 0;
        while (ngrant < 10 && cyc < 200) begin
            @(negedge clk_i);
            if (if_gnt_o || lsu_gnt_o) begin
                got_c = lsu_gnt_o ? "L" : "I";
                exp_c = ((ngrant % (SMAX + 1)) == SMAX) ? "I" : "L";
                check($sformatf("starve grant %0d", ngrant), {152'd0, got_c}, {152'd0, exp_c});
                ngrant++;
            end
            cyc++;
        end
        if (ngrant < 10) check("starve timeout", 160'(ngrant), 160'd10);

        // Asynchronous reset while a response is outstanding.
        do_reset(0);
        @(posedge clk_i); #1;
        lsu_req_i = 1; lsu_addr_i = 32'h300; lsu_be_i = 4'h3;
        @(posedge clk_i); #1;
        mem_gnt_i = 1;
        @(posedge clk_i); #1;
        lsu_req_i = 0; mem_gnt_i = 0; mem_rdata_i = 32'h55AA55AA;
        #2;
        rst_ni = 0; mem_rvalid_i = 1;
        #1;
        check("async reset mid rsp", dut_bundle(), 160'd0);
        @(negedge clk_i);
        rst_ni = 1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("stale rvalid ignored", dut_bundle(), 160'd0);

        // Randomized traffic against the transaction-level model.
        do_reset(0);
        m_busy = 0; m_granted = 0; m_killed = 0; m_own = 0; m_streak = 0; m_out = 0;
        m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
        s_ig = 0; s_lg = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_i); #1;
            if_kill_i = ($urandom_range(0, 19) == 0);
            if (if_kill_i || !if_req_i || s_ig) begin
                if_req_i  = ($urandom_range(0, 2) != 0);
                if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsu_req_i || s_lg) begin
                lsu_req_i   = ($urandom_range(0, 1) != 0);
                lsu_we_i    = $urandom_range(0, 1) != 0;
                lsu_be_i    = 4'($urandom);
                lsu_addr_i  = $urandom;
                lsu_wdata_i = $urandom;
            end
            mem_gnt_i    = mem_req_o ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 9) == 0);
            mem_rvalid_i = (m_out != 0) ? ($urandom_range(0, 1) != 0)
                                        : ($urandom_range(0, 9) == 0);
            mem_rdata_i  = $urandom;
            @(negedge clk_i);

            e_mreq = m_busy && !m_granted;
            e_ig   = e_mreq && mem_gnt_i && (m_own == 1);
            e_lg   = e_mreq && mem_gnt_i && (m_own == 2);
            e_resp = m_busy && m_granted && mem_rvalid_i;
            e_irv  = e_resp && (m_own == 1) && !m_killed && !if_kill_i;
            e_lrv  = e_resp && (m_own == 2);
            e_ird  = e_irv ? mem_rdata_i : 32'h0;
            e_lrd  = (e_lrv && !m_we) ? mem_rdata_i : 32'h0;
            exp_b  = bundle(e_mreq, e_ig, e_lg, e_irv, e_lrv, e_ird, e_lrd,
                            if_req_i && !e_irv, lsu_req_i && !e_lrv, m_addr, m_we, m_be, m_wdata);
            check($sformatf("random cycle %0d", c), dut_bundle(), exp_b);

            // Advance the model with this cycle's inputs.
            free = !m_busy;
            if (m_busy && (m_own == 1) && if_kill_i) m_killed = 1;
            if (m_busy && !m_granted) begin
                if (mem_gnt_i) m_granted = 1;
            end else if (m_busy && mem_rvalid_i) begin
                m_busy = 0;
                free   = 1;
            end
            if (free) begin
                ifp = if_req_i && !if_kill_i;
                if (lsu_req_i && !(ifp && m_streak == SMAX)) begin
                    m_busy = 1; m_granted = 0; m_killed = 0; m_own = 2;
                    m_we = lsu_we_i; m_be = lsu_be_i; m_addr = lsu_addr_i; m_wdata = lsu_wdata_i;
                    m_streak = if_req_i ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
                end else if (ifp) begin
                    m_busy = 1; m_granted = 0; m_killed = 0; m_own = 1;
                    m_we = 0; m_be = 4'hF; m_addr = if_addr_i; m_wdata = 32'h0;
                    m_streak = 0;
                end else begin
                    m_own = 0;
                end
            end

            if (m_out != 0 && mem_rvalid_i) m_out = 0;
            else if (mem_req_o && mem_gnt_i) m_out = 1;
            s_ig = if_gnt_o;
            s_lg = lsu_gnt_o;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
